// File: rtl/nv_ram_rws_64x256_fifo_ctrl.sv
// nv_ram_rws_64x256_fifo_ctrl: valid/ready FIFO sequencer for a 1R1W RAM with registered read address.
// The RAM output register holds the head word, so no extra data storage is needed for 1 word/cycle reads.
module nv_ram_rws_64x256_fifo_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 256
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          fifo_clr,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   fifo_count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_unread;
    logic          r_out_vld;
    logic          w_push;
    logic          w_pop;
    logic          w_fetch;

    // count includes the word parked in the RAM output register, so that slot is never overwritten
    assign wr_prdy    = nvdla_core_rstn & (r_count < FULL) & !fifo_clr;
    assign w_push     = wr_pvld & wr_prdy;
    assign w_pop      = r_out_vld & rd_prdy & !fifo_clr;
    assign w_fetch    = (r_unread != '0) & (!r_out_vld | rd_prdy) & !fifo_clr;
    assign ram_we     = w_push;
    assign ram_wa     = r_wr_ptr;
    assign ram_di     = wr_pd;
    assign ram_re     = w_fetch;
    assign ram_ra     = r_rd_ptr;
    assign rd_pvld    = r_out_vld;
    assign rd_pd      = ram_dout;
    assign fifo_count = r_count;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_unread  <= '0;
            r_out_vld <= 1'b0;
        end else if (fifo_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_unread  <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + AW'(w_push);
            r_rd_ptr  <= r_rd_ptr + AW'(w_fetch);
            r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_unread  <= r_unread + (AW+1)'(w_push) - (AW+1)'(w_fetch);
            r_out_vld <= w_fetch | (r_out_vld & !w_pop);
        end
    end
endmodule

// File: tb/tb_nv_ram_rws_64x256_fifo_ctrl.sv
// tb_nv_ram_rws_64x256_fifo_ctrl: directed and scoreboarded checks of the FIFO sequencer
// against a behavioural 64x256 RAM with registered read output.
module tb_nv_ram_rws_64x256_fifo_ctrl;
    localparam int DW = 256;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fifo_clr = 1'b0;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   fifo_count;
    logic [DW-1:0] mem [64];
    int            chk = 0;
    int            pass = 0;

    nv_ram_rws_64x256_fifo_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .fifo_clr       (fifo_clr),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_we         (ram_we),
        .ram_wa         (ram_wa),
        .ram_di         (ram_di),
        .ram_re         (ram_re),
        .ram_ra         (ram_ra),
        .ram_dout       (ram_dout),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    function automatic logic [DW-1:0] word(input int k);
        return {8{32'(k) ^ 32'h5A00_0000}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wr_pvld = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk++; if (ram_we !== 1'b0) $display("FAIL rst_we got %0b exp 0", ram_we); else pass++;
        chk++; if (ram_re !== 1'b0) $display("FAIL rst_re got %0b exp 0", ram_re); else pass++;
        chk++; if (rd_pvld !== 1'b0) $display("FAIL rst_rd_pvld got %0b exp 0", rd_pvld); else pass++;
        chk++; if (fifo_count !== 7'd0) $display("FAIL rst_count got %0d exp 0", fifo_count); else pass++;
        wr_pvld = 1'b0;
        rstn = 1'b1;
        #1;
        chk++; if (wr_prdy !== 1'b1) $display("FAIL rst_wr_prdy got %0b exp 1", wr_prdy); else pass++;
        cyc();
    endtask

    task automatic test_fresh_word(input string tag, input logic [DW-1:0] d);
        wr_pvld = 1'b1;
        wr_pd = d;
        rd_prdy = 1'b0;
        #1;
        chk++; if (ram_we !== 1'b1 || ram_wa !== 6'd0) $display("FAIL %s_we we=%0b wa=%0d exp we=1 wa=0", tag, ram_we, ram_wa); else pass++;
        cyc();
        wr_pvld = 1'b0;
        #1;
        chk++; if (ram_re !== 1'b1 || ram_ra !== 6'd0) $display("FAIL %s_re re=%0b ra=%0d exp re=1 ra=0", tag, ram_re, ram_ra); else pass++;
        chk++; if (rd_pvld !== 1'b0) $display("FAIL %s_early_vld got %0b exp 0", tag, rd_pvld); else pass++;
        cyc();
        chk++; if (rd_pvld !== 1'b1 || rd_pd !== d) $display("FAIL %s_out vld=%0b pd=%h exp vld=1 pd=%h", tag, rd_pvld, rd_pd, d); else pass++;
        rd_prdy = 1'b1;
        cyc();
        rd_prdy = 1'b0;
        #1;
        chk++; if (rd_pvld !== 1'b0 || fifo_count !== 7'd0) $display("FAIL %s_drain vld=%0b count=%0d exp 0/0", tag, rd_pvld, fifo_count); else pass++;
    endtask

    task automatic test_single();
        test_fresh_word("single", {{31{8'h5A}}, 8'hA5});
        cyc();
    endtask

    task automatic test_fill_full();
        rd_prdy = 1'b0;
        for (int k = 0; k < 64; k++) begin
            wr_pvld = 1'b1;
            wr_pd = word(k);
            #1;
            chk++; if (wr_prdy !== 1'b1) $display("FAIL fill_rdy k=%0d got 0 exp 1", k); else pass++;
            cyc();
        end
        wr_pvld = 1'b0;
        #1;
        chk++; if (wr_prdy !== 1'b0) $display("FAIL full_rdy got %0b exp 0", wr_prdy); else pass++;
        chk++; if (fifo_count !== 7'd64) $display("FAIL full_count got %0d exp 64", fifo_count); else pass++;
        chk++; if (rd_pvld !== 1'b1 || rd_pd !== word(0)) $display("FAIL full_head vld=%0b pd=%h exp 1/%h", rd_pvld, rd_pd, word(0)); else pass++;
        wr_pvld = 1'b1;
        wr_pd = word(99);
        rd_prdy = 1'b1;
        #1;
        chk++; if (ram_we !== 1'b0) $display("FAIL full_pushpop_we got %0b exp 0", ram_we); else pass++;
        cyc();
        wr_pvld = 1'b0;
        #1;
        chk++; if (fifo_count !== 7'd63) $display("FAIL full_pop_count got %0d exp 63", fifo_count); else pass++;
        chk++; if (wr_prdy !== 1'b1) $display("FAIL full_pop_rdy got %0b exp 1", wr_prdy); else pass++;
        for (int k = 1; k < 64; k++) begin
            chk++; if (rd_pvld !== 1'b1 || rd_pd !== word(k)) $display("FAIL drain k=%0d vld=%0b pd=%h exp 1/%h", k, rd_pvld, rd_pd, word(k)); else pass++;
            cyc();
        end
        rd_prdy = 1'b0;
        #1;
        chk++; if (rd_pvld !== 1'b0 || fifo_count !== 7'd0) $display("FAIL drain_end vld=%0b count=%0d exp 0/0", rd_pvld, fifo_count); else pass++;
        cyc();
    endtask

    task automatic test_stream();
        // pointers start at 1 after the single word and the 64-word fill/drain
        for (int c = 0; c < 202; c++) begin
            wr_pvld = (c < 200);
            wr_pd = word(1000 + c);
            rd_prdy = 1'b1;
            #1;
            if (c < 200) begin
                chk++; if (ram_we !== 1'b1 || ram_wa !== 6'(1 + c)) $display("FAIL stream_wa c=%0d we=%0b wa=%0d exp 1/%0d", c, ram_we, ram_wa, 6'(1 + c)); else pass++;
            end
            if (c >= 1 && c <= 200) begin
                chk++; if (ram_re !== 1'b1 || ram_ra !== 6'(c)) $display("FAIL stream_ra c=%0d re=%0b ra=%0d exp 1/%0d", c, ram_re, ram_ra, 6'(c)); else pass++;
            end
            if (c >= 2) begin
                chk++; if (rd_pvld !== 1'b1 || rd_pd !== word(1000 + c - 2)) $display("FAIL stream_out c=%0d vld=%0b pd=%h exp 1/%h", c, rd_pvld, rd_pd, word(1000 + c - 2)); else pass++;
            end
            chk++; if (fifo_count > 7'd2) $display("FAIL stream_count c=%0d got %0d exp <=2", c, fifo_count); else pass++;
            cyc();
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        #1;
        chk++; if (rd_pvld !== 1'b0 || fifo_count !== 7'd0) $display("FAIL stream_end vld=%0b count=%0d exp 0/0", rd_pvld, fifo_count); else pass++;
        cyc();
    endtask

    task automatic test_random();
        logic [DW-1:0] sb [$];
        logic [AW-1:0] iss [$];
        logic [DW-1:0] hpd = '0;
        logic [DW-1:0] exp_pd;
        logic          hold = 1'b0;
        logic          found;
        int            pushed = 0;
        int            popped = 0;
        int            n = 0;
        while (popped < 1000 && n < 20000) begin
            wr_pvld = (pushed < 1000) && 1'($urandom_range(0, 1));
            wr_pd = {8{$urandom()}};
            rd_prdy = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                chk++; if (rd_pvld !== 1'b1 || rd_pd !== hpd) $display("FAIL rand_hold n=%0d vld=%0b pd=%h exp 1/%h", n, rd_pvld, rd_pd, hpd); else pass++;
            end
            if (ram_we) begin
                found = 1'b0;
                foreach (iss[i]) if (iss[i] == ram_wa) found = 1'b1;
                chk++; if (found) $display("FAIL rand_overwrite n=%0d wa=%0d got issued=1 exp 0", n, ram_wa); else pass++;
            end
            if (wr_pvld && wr_prdy) begin
                sb.push_back(wr_pd);
                pushed++;
            end
            if (rd_pvld && rd_prdy) begin
                exp_pd = (sb.size() != 0) ? sb.pop_front() : 'x;
                chk++; if (rd_pd !== exp_pd) $display("FAIL rand_data pop=%0d got %h exp %h", popped, rd_pd, exp_pd); else pass++;
                if (iss.size() != 0) void'(iss.pop_front());
                popped++;
            end
            if (ram_re) iss.push_back(ram_ra);
            hold = rd_pvld && !rd_prdy;
            hpd = rd_pd;
            cyc();
            n++;
        end
        chk++; if (popped != 1000) $display("FAIL rand_timeout popped=%0d exp 1000", popped); else pass++;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        cyc();
    endtask

    task automatic fill10(input int base);
        rd_prdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wr_pvld = 1'b1;
            wr_pd = word(base + k);
            cyc();
        end
        wr_pvld = 1'b0;
        #1;
    endtask

    task automatic test_clr();
        fill10(500);
        chk++; if (fifo_count !== 7'd10) $display("FAIL clr_pre_count got %0d exp 10", fifo_count); else pass++;
        fifo_clr = 1'b1;
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        #1;
        chk++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) $display("FAIL clr_strobes rdy=%0b we=%0b re=%0b exp 0/0/0", wr_prdy, ram_we, ram_re); else pass++;
        cyc();
        fifo_clr = 1'b0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        #1;
        chk++; if (fifo_count !== 7'd0 || rd_pvld !== 1'b0) $display("FAIL clr_state count=%0d vld=%0b exp 0/0", fifo_count, rd_pvld); else pass++;
        test_fresh_word("clr", word(7777));
        cyc();
    endtask

    task automatic test_async_reset();
        fill10(600);
        wr_pvld = 1'b1;
        wr_pd = word(610);
        rd_prdy = 1'b1;
        cyc();
        #2;
        rstn = 1'b0;
        #1;
        chk++; if (fifo_count !== 7'd0 || rd_pvld !== 1'b0) $display("FAIL arst_state count=%0d vld=%0b exp 0/0", fifo_count, rd_pvld); else pass++;
        chk++; if (ram_we !== 1'b0 || ram_re !== 1'b0) $display("FAIL arst_strobes we=%0b re=%0b exp 0/0", ram_we, ram_re); else pass++;
        @(posedge clk);
        #3;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        rstn = 1'b1;
        #1;
        chk++; if (wr_prdy !== 1'b1) $display("FAIL arst_rdy got %0b exp 1", wr_prdy); else pass++;
        cyc();
        test_fresh_word("arst", word(8888));
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_stream();
        test_random();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d of %0d checks", pass, chk);
        $fatal(1, "watchdog");
    end
endmodule
